layer_collector: RTL
====================

LAYER_COLLECTOR -- requirements
Module: layer_collector

Interface
REQ-001 SHALL have parameter NumNeurons, default 4: number of upstream neurons (activation lanes).
REQ-002 SHALL have parameter DataWidth, default 8: activation width.
REQ-003 SHALL have parameter NumConsumers, default 4: number of downstream neurons fed in parallel.
REQ-004 SHALL have port clk_i, input, 1: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset_i, input, 1: reset, asynchronous and active-high.
REQ-006 SHALL have port in_req_i, input, NumNeurons: per-lane request from upstream neuron req_o.
REQ-007 SHALL have port in_actv_i, input, DataWidth*NumNeurons: lane k activation at [DataWidth*k +: DataWidth].
REQ-008 SHALL have port in_ack_o, output, NumNeurons: per-lane ack, wired to every ack_i bit of upstream neuron k.
REQ-009 SHALL have port out_req_o, output, NumNeurons: per-lane request to the req_i of every consumer.
REQ-010 SHALL have port out_actv_o, output, DataWidth*NumNeurons: registered activation vector, same packing as in_actv_i.
REQ-011 SHALL have port out_ack_i, input, NumConsumers*NumNeurons: bit [NumNeurons*c + k] is consumer c's ack_o[k].
REQ-012 SHALL have port busy_o, output, 1: high whenever state is not ST_COLLECT or any lane is captured.
REQ-013 SHALL have port frame_cnt_o, output, 16: count of completed frames.

Function
REQ-014 SHALL implement states ST_COLLECT, ST_PRESENT, ST_RELEASE.
REQ-015 In ST_COLLECT, for each lane k with in_req_i[k]=1 and captured[k]=0: next edge latches lane data into out_actv_o, sets captured[k], drives in_ack_o[k]=1 for exactly one cycle.
REQ-016 A lane with captured[k]=1 SHALL be ignored (no re-capture, no ack) even if in_req_i[k] stays high.
REQ-017 Multiple lanes requesting in the same cycle SHALL all be captured and acked in that same cycle.
REQ-018 When captured is all-ones (including lanes captured that edge), next state ST_PRESENT with out_req_o all-ones; latency last-capture-to-out_req_o = 1 cycle after the capture edge.
REQ-019 In ST_PRESENT, a sticky bit per (consumer, lane) SHALL set when its out_ack_i bit is sampled high; out_actv_o SHALL be held constant.
REQ-020 When sticky OR current out_ack_i is all-ones, out_req_o SHALL drop to zero at the next edge and state SHALL go to ST_RELEASE.
REQ-021 In ST_RELEASE, when out_ack_i is all-zeros: clear captured and sticky bits, increment frame_cnt_o (wraps 0xFFFF->0x0000), go to ST_COLLECT.
REQ-022 Upstream requests arriving in ST_PRESENT or ST_RELEASE SHALL be neither acked nor captured until ST_COLLECT.
REQ-023 out_actv_o lanes SHALL be plain copies; no arithmetic, truncation or sign change.
REQ-024 in_ack_o SHALL be zero outside ST_COLLECT.

Reset
REQ-025 reset_i asserted at any time, including mid-frame, SHALL immediately force ST_COLLECT, captured/sticky=0, in_ack_o=0, out_req_o=0, out_actv_o=0, frame_cnt_o=0, busy_o=0.
REQ-026 After reset_i deasserts, the first frame SHALL start fresh; partially captured data is discarded.

Structure
REQ-027 State enum (st_collector_e) and frame counter width constant SHALL live in the shared nn_pkg package.
REQ-028 Sticky ack tracking SHALL be one sub-module, ack_gather (parameters NumConsumers, NumNeurons; inputs clear, enable, acks; output all_acked).

Verification
REQ-029 NumNeurons=4: lanes 0..3 request simultaneously with 0x11,0x22,0x33,0x44 -> in_ack_o=4'b1111 one cycle, out_actv_o=0x44332211, out_req_o=4'b1111 next cycle.
REQ-030 Lanes arrive staggered (3,1,0,2) one cycle apart, each req held 3 cycles -> each lane acked once only, out_req_o rises one cycle after lane 2 capture.
REQ-031 NumConsumers=4, consumers ack on different cycles (cycles 2,5,5,9 after out_req_o) -> out_req_o falls edge after cycle 9; not earlier.
REQ-032 Lane 0 requests new data 0x7F during ST_PRESENT -> no ack, out_actv_o unchanged; captured after return to ST_COLLECT.
REQ-033 reset_i pulsed after 2 of 4 lanes captured -> all outputs zero asynchronously; next full frame yields frame_cnt_o=1.
REQ-034 Preload via 65535 frames -> next completed frame gives frame_cnt_o=0.

Source files
------------

// File: rtl/nn_pkg.sv
// Shared types for the neural-layer handshake fabric.
// Holds the collector state encoding and the frame counter width.
package nn_pkg;

    localparam int FrameCntW = 16;

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_PRESENT = 2'd1,
        ST_RELEASE = 2'd2
    } st_collector_e;

endpackage

// File: rtl/ack_gather.sv
// Sticky per-(consumer, lane) ack tracker; all_acked counts a bit seen now or earlier.
// Latency: all_acked is combinational on acks, sticky bits update on the next edge.
// Backpressure: none; acks are only remembered while enable is high.
module ack_gather #(
    parameter int NumConsumers = 4,
    parameter int NumNeurons   = 4
) (
    input  logic                               clk_i,
    input  logic                               reset_i,
    input  logic                               clear,
    input  logic                               enable,
    input  logic [NumConsumers*NumNeurons-1:0] acks,
    output logic                               all_acked
);

    logic [NumConsumers*NumNeurons-1:0] sticky_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            sticky_q <= '0;
        end else if (clear) begin
            sticky_q <= '0;
        end else if (enable) begin
            sticky_q <= sticky_q | acks;
        end
    end

    assign all_acked = &(sticky_q | acks);

endmodule

// File: rtl/layer_collector.sv
// Gathers one activation per upstream lane into a frame and broadcasts it to all consumers.
// Latency: lane ack one cycle after its request; out_req_o one cycle after the final lane ack.
// Backpressure: upstream waits for in_ack_o; the frame is held until every consumer acks every lane.
module layer_collector
    import nn_pkg::*;
#(
    parameter int NumNeurons   = 4,
    parameter int DataWidth    = 8,
    parameter int NumConsumers = 4
) (
    input  logic                               clk_i,
    input  logic                               reset_i,
    input  logic [NumNeurons-1:0]              in_req_i,
    input  logic [DataWidth*NumNeurons-1:0]    in_actv_i,
    output logic [NumNeurons-1:0]              in_ack_o,
    output logic [NumNeurons-1:0]              out_req_o,
    output logic [DataWidth*NumNeurons-1:0]    out_actv_o,
    input  logic [NumConsumers*NumNeurons-1:0] out_ack_i,
    output logic                               busy_o,
    output logic [FrameCntW-1:0]               frame_cnt_o
);

    st_collector_e          state_q, state_d;
    logic [NumNeurons-1:0]  captured_q;
    logic [NumNeurons-1:0]  cap_set;
    logic                   frame_done;
    logic                   all_acked;
    logic [FrameCntW-1:0]   frame_cnt_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= ST_COLLECT;
        end else begin
            state_q <= state_d;
        end
    end

    // PRESENT is entered from the registered capture mask, so the last lane's
    // ack cycle is still spent in COLLECT and in_ack_o never leaks past it.
    always_comb begin
        state_d    = state_q;
        cap_set    = '0;
        frame_done = 1'b0;
        unique case (state_q)
            ST_COLLECT: begin
                cap_set = in_req_i & ~captured_q;
                if (&captured_q) begin
                    state_d = ST_PRESENT;
                end
            end
            ST_PRESENT: begin
                if (all_acked) begin
                    state_d = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                if (out_ack_i == '0) begin
                    state_d    = ST_COLLECT;
                    frame_done = 1'b1;
                end
            end
            default: begin
                state_d = ST_COLLECT;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            captured_q  <= '0;
            in_ack_o    <= '0;
            out_req_o   <= '0;
            out_actv_o  <= '0;
            frame_cnt_q <= '0;
        end else begin
            captured_q <= frame_done ? '0 : (captured_q | cap_set);
            in_ack_o   <= cap_set;
            out_req_o  <= {NumNeurons{state_d == ST_PRESENT}};
            for (int k = 0; k < NumNeurons; k++) begin
                if (cap_set[k]) begin
                    out_actv_o[DataWidth*k +: DataWidth] <= in_actv_i[DataWidth*k +: DataWidth];
                end
            end
            if (frame_done) begin
                frame_cnt_q <= frame_cnt_q + FrameCntW'(1);
            end
        end
    end

    ack_gather #(
        .NumConsumers (NumConsumers),
        .NumNeurons   (NumNeurons)
    ) u_ack_gather (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .clear     (frame_done),
        .enable    (state_q == ST_PRESENT),
        .acks      (out_ack_i),
        .all_acked (all_acked)
    );

    assign frame_cnt_o = frame_cnt_q;
    assign busy_o      = (state_q != ST_COLLECT) || (|captured_q);

endmodule
